sram_responder: RTL

Memory-side responder for the LC-3 datapath's SRAM bus: it answers the control unit's active-low chip-enable, output-enable, write-enable and byte-lane strobes with multi-cycle read and write timing. It holds an on-chip word array and a memory-mapped I/O word at 16'hFFFF (switches on read, hex display on write). It sits between the CPU's MAR/MDR datapath and the board, and acts as the bench-visible memory model for control-unit fetch, load and store states.

---
 rtl/mem_bus_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/sram_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the SRAM bus responder.
package mem_bus_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_HOLD,
    WR_WAIT,
    WR_HOLD
  } sram_state_t;

  // Memory-mapped I/O word: switches on read, hex display on write.
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  // Consecutive write cycles needed before the write commits.
  localparam int WR_CYCLES = 2;

  // Replace the byte lanes whose active-low enable is asserted; keep the rest.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic        ub_n,
                                             input logic        lb_n);
    logic [15:0] merged;
    merged = old_word;
    if (!ub_n) merged[15:8] = new_word[15:8];
    if (!lb_n) merged[7:0]  = new_word[7:0];
    return merged;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the raw input through two stages; both clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sram_responder.sv
// SRAM bus responder: multi-cycle read/write handshake on active-low strobes,
// backed by an on-chip word array plus one memory-mapped I/O word.
module sram_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_valid,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out,
  output logic        Busy,
  output logic        Error
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RD_CNT_INIT = 2'(READ_LAT - 1);
  localparam logic [1:0] WR_CNT_INIT = 2'(WR_CYCLES - 2);

  // Word array; contents survive reset.
  logic [15:0] mem [DEPTH_WORDS];

  sram_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic [15:0] hex_q, hex_d;
  logic        error_q, error_d;

  logic        rd_req;
  logic        wr_req;
  logic [15:0] sw_sync;
  logic [15:0] rd_sel_addr;
  logic        rd_ub_n;
  logic        rd_lb_n;
  logic [15:0] rd_word;
  logic [15:0] rd_data;
  logic        mem_we;
  logic [15:0] wr_word;

  sync_2ff #(.WIDTH(16)) u_sw_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (Switches),
    .q   (sw_sync)
  );

  // Bus decode; a write takes priority when OE and WE are both low.
  always_comb begin
    wr_req = !Mem_CE && !Mem_WE;
    rd_req = !Mem_CE && !Mem_OE && Mem_WE;
  end

  // Read source: live bus in IDLE (single-cycle latency case), latched afterwards.
  always_comb begin
    rd_sel_addr = (state_q == IDLE) ? ADDR   : addr_q;
    rd_ub_n     = (state_q == IDLE) ? Mem_UB : ub_n_q;
    rd_lb_n     = (state_q == IDLE) ? Mem_LB : lb_n_q;
    rd_word     = (rd_sel_addr == IO_ADDR) ? sw_sync : mem[rd_sel_addr[AW-1:0]];
    rd_data     = lane_merge(16'h0000, rd_word, rd_ub_n, rd_lb_n);
    wr_word     = lane_merge(mem[addr_q[AW-1:0]], wdata_q, ub_n_q, lb_n_q);
  end

  // Next-state and output logic for the read/write handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ub_n_d     = ub_n_q;
    lb_n_d     = lb_n_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    hex_d      = hex_q;
    error_d    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          addr_d  = ADDR;
          ub_n_d  = Mem_UB;
          lb_n_d  = Mem_LB;
          wdata_d = Data_in;
        end
        if (wr_req) begin
          cnt_d   = WR_CNT_INIT;
          state_d = WR_WAIT;
        end else if (rd_req) begin
          if (READ_LAT == 1) begin
            data_out_d = rd_data;
            valid_d    = 1'b1;
            state_d    = RD_HOLD;
          end else begin
            cnt_d   = RD_CNT_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!rd_req) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd1) begin
          // The decrement that would reach zero is the data load edge.
          cnt_d      = 2'd0;
          data_out_d = rd_data;
          valid_d    = 1'b1;
          state_d    = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_HOLD: begin
        if (!rd_req) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (!wr_req) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          if (addr_q == IO_ADDR) begin
            hex_d = lane_merge(hex_q, wdata_q, ub_n_q, lb_n_q);
          end else begin
            mem_we = 1'b1;
          end
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WR_HOLD: begin
        if (!wr_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset abandons any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= 16'h0000;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      wdata_q    <= 16'h0000;
      data_out_q <= 16'h0000;
      valid_q    <= 1'b0;
      hex_q      <= 16'h0000;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      hex_q      <= hex_d;
      error_q    <= error_d;
    end
  end

  // Array write port; reset drops state to IDLE first, so no commit escapes it.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[addr_q[AW-1:0]] <= wr_word;
  end

  assign Data_out   = data_out_q;
  assign Data_valid = valid_q;
  assign Hex_out    = hex_q;
  assign Error      = error_q;
  assign Busy       = (state_q != IDLE);

endmodule
